// File: rtl/fetch_dec_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dec_queue
// Brief    : Multi-issue circular instruction queue between fetch and decode.
//            Define FDQ_STALL_CNT_EN to add the saturating fetch-stall counter.
// Revision : 1.0
// ============================================================================
module fetch_dec_queue #(
   parameter int ADDR        = 32,
   parameter int INST        = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int DEC_WIDTH   = 2,
   parameter int DEPTH       = 8
) (
   input  logic                             clk,
   input  logic                             reset_,
   input  logic                             flush,
   input  logic [FETCH_WIDTH-1:0]           fe_valid,
   input  logic [FETCH_WIDTH*ADDR-1:0]      fe_pc,
   input  logic [FETCH_WIDTH*INST-1:0]      fe_inst,
   input  logic [FETCH_WIDTH-1:0]           fe_pred,
   output logic                             fe_ready,
   output logic [DEC_WIDTH-1:0]             dec_valid,
   output logic [DEC_WIDTH*ADDR-1:0]        dec_pc,
   output logic [DEC_WIDTH*INST-1:0]        dec_inst,
   output logic [DEC_WIDTH-1:0]             dec_pred,
   input  logic [$clog2(DEC_WIDTH+1)-1:0]   dec_pop,
`ifdef FDQ_STALL_CNT_EN
   output logic [31:0]                      stall_cnt,
`endif
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR-1:0]  pc_mem_q   [DEPTH];
   logic [INST-1:0]  inst_mem_q [DEPTH];
   logic [DEPTH-1:0] pred_mem_q;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] push_n, pop_n;
   logic             push_en;

   always_comb begin
      // Only the registered count is used, so a same-cycle pop never frees space.
      fe_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(FETCH_WIDTH);
      push_en  = fe_ready & ~flush;
      push_n   = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         push_n = push_n + CNT_W'(fe_valid[i] & push_en);
      end
      if (32'(dec_pop) < 32'(count_q)) begin
         pop_n = CNT_W'(dec_pop);
      end else begin
         pop_n = count_q;
      end
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + push_n - pop_n;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset; dec_valid masks stale entries.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (push_en && fe_valid[i]) begin
            pc_mem_q[tail_q + PTR_W'(i)]   <= fe_pc[i*ADDR +: ADDR];
            inst_mem_q[tail_q + PTR_W'(i)] <= fe_inst[i*INST +: INST];
            pred_mem_q[tail_q + PTR_W'(i)] <= fe_pred[i];
         end
      end
   end

   generate
      for (genvar j = 0; j < DEC_WIDTH; j++) begin : g_dec
         localparam logic [PTR_W-1:0] OFF = PTR_W'(j);
         assign dec_valid[j]               = 32'(j) < 32'(count_q);
         assign dec_pc[j*ADDR +: ADDR]     = pc_mem_q[head_q + OFF];
         assign dec_inst[j*INST +: INST]   = inst_mem_q[head_q + OFF];
         assign dec_pred[j]                = pred_mem_q[head_q + OFF];
      end
   endgenerate

   assign count = count_q;

`ifdef FDQ_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((|fe_valid) && !fe_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

   a_fe_valid_thermo: assert property (@(posedge clk) disable iff (reset_)
      ((fe_valid & (fe_valid + FETCH_WIDTH'(1))) == '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_dec_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_dec_queue
// Brief    : Directed self-checking bench for fetch_dec_queue (default params).
// Revision : 1.0
// ============================================================================
module tb_fetch_dec_queue;

   logic        clk;
   logic        reset_;
   logic        flush;
   logic [1:0]  fe_valid;
   logic [63:0] fe_pc;
   logic [63:0] fe_inst;
   logic [1:0]  fe_pred;
   logic        fe_ready;
   logic [1:0]  dec_valid;
   logic [63:0] dec_pc;
   logic [63:0] dec_inst;
   logic [1:0]  dec_pred;
   logic [1:0]  dec_pop;
   logic [3:0]  count;
`ifdef FDQ_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int total  = 0;
   int passed = 0;

   fetch_dec_queue dut (
      .clk       (clk),
      .reset_    (reset_),
      .flush     (flush),
      .fe_valid  (fe_valid),
      .fe_pc     (fe_pc),
      .fe_inst   (fe_inst),
      .fe_pred   (fe_pred),
      .fe_ready  (fe_ready),
      .dec_valid (dec_valid),
      .dec_pc    (dec_pc),
      .dec_inst  (dec_inst),
      .dec_pred  (dec_pred),
      .dec_pop   (dec_pop),
`ifdef FDQ_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_group(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
      fe_valid = v;
      fe_pc    = {pc1, pc0};
      fe_inst  = {~pc1, ~pc0};
      fe_pred  = 2'b00;
   endtask

   task automatic idle;
      fe_valid = 2'b00;
      dec_pop  = 2'd0;
      flush    = 1'b0;
   endtask

   task automatic test_reset;
      reset_ = 1'b1;
      idle();
      fe_pc = '0; fe_inst = '0; fe_pred = '0;
      repeat (2) @(posedge clk);
      #1 reset_ = 1'b0;
      step();
      total++; if (count !== 4'd0) $display("FAIL reset_count actual=%0d required=0", count); else passed++;
      total++; if (dec_valid !== 2'b00) $display("FAIL reset_dec_valid actual=%b required=00", dec_valid); else passed++;
      total++; if (fe_ready !== 1'b1) $display("FAIL reset_fe_ready actual=%b required=1", fe_ready); else passed++;
`ifdef FDQ_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt actual=%0d required=0", stall_cnt); else passed++;
`endif
   endtask

   task automatic test_basic;
      set_group(2'b11, 32'h100, 32'h104);
      fe_pred = 2'b10;
      step();
      idle();
      total++; if (dec_valid !== 2'b11) $display("FAIL basic_dec_valid actual=%b required=11", dec_valid); else passed++;
      total++; if (dec_pc !== {32'h104, 32'h100}) $display("FAIL basic_dec_pc actual=%h required=%h", dec_pc, {32'h104, 32'h100}); else passed++;
      total++; if (dec_inst !== {~32'h104, ~32'h100}) $display("FAIL basic_dec_inst actual=%h required=%h", dec_inst, {~32'h104, ~32'h100}); else passed++;
      total++; if (dec_pred !== 2'b10) $display("FAIL basic_dec_pred actual=%b required=10", dec_pred); else passed++;
      total++; if (count !== 4'd2) $display("FAIL basic_count actual=%0d required=2", count); else passed++;
      dec_pop = 2'd2;
      step();
      idle();
      total++; if (count !== 4'd0) $display("FAIL basic_pop_count actual=%0d required=0", count); else passed++;
      total++; if (dec_valid !== 2'b00) $display("FAIL basic_pop_valid actual=%b required=00", dec_valid); else passed++;
   endtask

   task automatic test_fill;
      for (int k = 0; k < 4; k++) begin
         set_group(2'b11, 32'h300 + 32'(8*k), 32'h304 + 32'(8*k));
         step();
      end
      total++; if (count !== 4'd8) $display("FAIL fill_count actual=%0d required=8", count); else passed++;
      total++; if (fe_ready !== 1'b0) $display("FAIL fill_fe_ready actual=%b required=0", fe_ready); else passed++;
      set_group(2'b11, 32'h400, 32'h404);
      step();
      step();
      idle();
      total++; if (count !== 4'd8) $display("FAIL fill_hold_count actual=%0d required=8", count); else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dec_pc !== {32'h304 + 32'(8*k), 32'h300 + 32'(8*k)})
            $display("FAIL fill_drain_pc%0d actual=%h required=%h", k, dec_pc, {32'h304 + 32'(8*k), 32'h300 + 32'(8*k)});
         else passed++;
         dec_pop = 2'd2;
         step();
         idle();
      end
      total++; if (count !== 4'd0) $display("FAIL fill_drain_count actual=%0d required=0", count); else passed++;
   endtask

   task automatic test_wrap;
      logic [31:0] exp_pc;
      logic [31:0] nxt_pc;
      set_group(2'b11, 32'h1000, 32'h1004);
      step();
      set_group(2'b11, 32'h1008, 32'h100c);
      step();
      idle();
      exp_pc = 32'h1000;
      nxt_pc = 32'h1010;
      for (int k = 0; k < 10; k++) begin
         total++; if (dec_valid !== 2'b11) $display("FAIL wrap_valid%0d actual=%b required=11", k, dec_valid); else passed++;
         total++;
         if (dec_pc !== {exp_pc + 32'h4, exp_pc})
            $display("FAIL wrap_pc%0d actual=%h required=%h", k, dec_pc, {exp_pc + 32'h4, exp_pc});
         else passed++;
         set_group(2'b11, nxt_pc, nxt_pc + 32'h4);
         dec_pop = 2'd2;
         step();
         exp_pc = exp_pc + 32'h8;
         nxt_pc = nxt_pc + 32'h8;
         total++; if (count !== 4'd4) $display("FAIL wrap_count%0d actual=%0d required=4", k, count); else passed++;
      end
      idle();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dec_pc !== {exp_pc + 32'h4, exp_pc})
            $display("FAIL wrap_drain_pc%0d actual=%h required=%h", k, dec_pc, {exp_pc + 32'h4, exp_pc});
         else passed++;
         dec_pop = 2'd2;
         step();
         idle();
         exp_pc = exp_pc + 32'h8;
      end
      total++; if (count !== 4'd0) $display("FAIL wrap_drain_count actual=%0d required=0", count); else passed++;
   endtask

   task automatic test_partial;
      logic [31:0] lo;
      set_group(2'b01, 32'h200, 32'hDEAD);
      step();
      idle();
      lo = dec_pc[31:0];
      total++; if (dec_valid !== 2'b01) $display("FAIL partial_valid actual=%b required=01", dec_valid); else passed++;
      total++; if (lo !== 32'h200) $display("FAIL partial_pc actual=%h required=200", lo); else passed++;
      total++; if (count !== 4'd1) $display("FAIL partial_count actual=%0d required=1", count); else passed++;
      dec_pop = 2'd2;
      step();
      idle();
      total++; if (count !== 4'd0) $display("FAIL partial_overpop_count actual=%0d required=0", count); else passed++;
      total++; if (dec_valid !== 2'b00) $display("FAIL partial_overpop_valid actual=%b required=00", dec_valid); else passed++;
      set_group(2'b11, 32'h210, 32'h214);
      step();
      idle();
      total++; if (dec_pc !== {32'h214, 32'h210}) $display("FAIL partial_after_pc actual=%h required=%h", dec_pc, {32'h214, 32'h210}); else passed++;
      dec_pop = 2'd2;
      step();
      idle();
   endtask

   task automatic test_flush;
      set_group(2'b11, 32'h500, 32'h504);
      step();
      set_group(2'b11, 32'h508, 32'h50c);
      step();
      set_group(2'b01, 32'h510, 32'h0);
      step();
      idle();
      total++; if (count !== 4'd5) $display("FAIL flush_pre_count actual=%0d required=5", count); else passed++;
      flush = 1'b1;
      set_group(2'b11, 32'h600, 32'h604);
      dec_pop = 2'd2;
      step();
      idle();
      total++; if (count !== 4'd0) $display("FAIL flush_count actual=%0d required=0", count); else passed++;
      total++; if (dec_valid !== 2'b00) $display("FAIL flush_valid actual=%b required=00", dec_valid); else passed++;
      total++; if (fe_ready !== 1'b1) $display("FAIL flush_fe_ready actual=%b required=1", fe_ready); else passed++;
      set_group(2'b11, 32'h700, 32'h704);
      step();
      idle();
      total++; if (dec_pc !== {32'h704, 32'h700}) $display("FAIL flush_after_pc actual=%h required=%h", dec_pc, {32'h704, 32'h700}); else passed++;
      total++; if (count !== 4'd2) $display("FAIL flush_after_count actual=%0d required=2", count); else passed++;
      dec_pop = 2'd2;
      step();
      idle();
   endtask

   task automatic test_async_reset;
      set_group(2'b11, 32'h800, 32'h804);
      step();
      set_group(2'b11, 32'h808, 32'h80c);
      #2 reset_ = 1'b1;
      #1;
      total++; if (count !== 4'd0) $display("FAIL areset_count actual=%0d required=0", count); else passed++;
      total++; if (dec_valid !== 2'b00) $display("FAIL areset_valid actual=%b required=00", dec_valid); else passed++;
      total++; if (fe_ready !== 1'b1) $display("FAIL areset_fe_ready actual=%b required=1", fe_ready); else passed++;
      step();
      idle();
      reset_ = 1'b0;
      step();
      total++; if (count !== 4'd0) $display("FAIL areset_dropped_count actual=%0d required=0", count); else passed++;
`ifdef FDQ_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd0) $display("FAIL areset_stall_cnt actual=%0d required=0", stall_cnt); else passed++;
`endif
   endtask

`ifdef FDQ_STALL_CNT_EN
   task automatic test_stall_cnt;
      for (int k = 0; k < 4; k++) begin
         set_group(2'b11, 32'h900 + 32'(8*k), 32'h904 + 32'(8*k));
         step();
      end
      total++; if (stall_cnt !== 32'd0) $display("FAIL stall_fill actual=%0d required=0", stall_cnt); else passed++;
      set_group(2'b11, 32'hA00, 32'hA04);
      repeat (7) step();
      idle();
      total++; if (stall_cnt !== 32'd7) $display("FAIL stall_count actual=%0d required=7", stall_cnt); else passed++;
      flush = 1'b1;
      step();
      idle();
      total++; if (stall_cnt !== 32'd7) $display("FAIL stall_after_flush actual=%0d required=7", stall_cnt); else passed++;
      reset_ = 1'b1;
      #1;
      total++; if (stall_cnt !== 32'd0) $display("FAIL stall_after_reset actual=%0d required=0", stall_cnt); else passed++;
      step();
      reset_ = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_wrap();
      test_partial();
      test_flush();
      test_async_reset();
`ifdef FDQ_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
